// File: rtl/segmented_display_decoder.sv
// Segmented display decoder: watches a multiplexed 7/8-segment anode/cathode
// bus and recovers the hexadecimal digit and decimal point shown on each
// position. Inputs are synchronised, qualified by a stability counter, and
// each settled digit is captured into registered outputs.
module segmented_display_decoder #(
    parameter int NUMBER_OF_NYBBLES  = 4,
    parameter int NUMBER_OF_SEGMENTS = 7,
    parameter int SETTLE_CYCLES      = 16
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [NUMBER_OF_NYBBLES-1:0]   anode,
    input  logic [NUMBER_OF_SEGMENTS-1:0]  cathode,
    output logic [NUMBER_OF_NYBBLES*4-1:0] data,
    output logic [NUMBER_OF_NYBBLES-1:0]   dp,
    output logic [NUMBER_OF_NYBBLES-1:0]   digit_valid,
    output logic [NUMBER_OF_NYBBLES-1:0]   pattern_error,
    output logic                           frame_strobe
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] SETTLE_VAL = CW'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        HOLD
    } state_t;

    state_t                           r_state;
    logic [NUMBER_OF_NYBBLES-1:0]     r_anode_m;
    logic [NUMBER_OF_NYBBLES-1:0]     r_anode_s;
    logic [NUMBER_OF_SEGMENTS-1:0]    r_cath_m;
    logic [NUMBER_OF_SEGMENTS-1:0]    r_cath_s;
    logic [NUMBER_OF_NYBBLES-1:0]     r_prev_anode;
    logic [NUMBER_OF_SEGMENTS-1:0]    r_prev_cath;
    logic [CW-1:0]                    r_cnt;
    logic [NUMBER_OF_NYBBLES-1:0]     r_set;
    logic [NUMBER_OF_NYBBLES*4-1:0]   r_data;
    logic [NUMBER_OF_NYBBLES-1:0]     r_dp;
    logic [NUMBER_OF_NYBBLES-1:0]     r_valid;
    logic [NUMBER_OF_NYBBLES-1:0]     r_err;
    logic                             r_frame;

    logic                             w_changed;
    logic                             w_onehot;
    logic                             w_settled;
    logic                             w_capture;
    logic [NUMBER_OF_NYBBLES-1:0]     w_cap_mask;
    logic [6:0]                       w_abcdefg;
    logic [3:0]                       w_nybble;
    logic                             w_legal;
    logic                             w_dp_bit;

    assign w_changed  = {r_anode_s, r_cath_s} != {r_prev_anode, r_prev_cath};
    assign w_onehot   = $onehot(r_anode_s);
    assign w_settled  = (r_cnt == SETTLE_VAL) && !w_changed;
    assign w_capture  = (r_state == SETTLE) && w_onehot && w_settled;
    assign w_cap_mask = w_capture ? r_anode_s : '0;

    generate
        if (NUMBER_OF_SEGMENTS >= 8) begin : g_dp
            assign w_dp_bit = ~r_cath_s[NUMBER_OF_SEGMENTS-1];
        end else begin : g_no_dp
            assign w_dp_bit = 1'b0;
        end
    endgenerate

    // Two-flop synchronisers, previous-value register and stability counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_anode_m    <= '0;
            r_anode_s    <= '0;
            r_cath_m     <= '0;
            r_cath_s     <= '0;
            r_prev_anode <= '0;
            r_prev_cath  <= '0;
            r_cnt        <= '0;
        end else begin
            r_anode_m    <= anode;
            r_anode_s    <= r_anode_m;
            r_cath_m     <= cathode;
            r_cath_s     <= r_cath_m;
            r_prev_anode <= r_anode_s;
            r_prev_cath  <= r_cath_s;
            if (w_changed) begin
                r_cnt <= '0;
            end else if (r_cnt != SETTLE_VAL) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Segment pattern (a..g, 0 = lit) to nybble lookup
    always_comb begin
        w_abcdefg = {r_cath_s[0], r_cath_s[1], r_cath_s[2], r_cath_s[3],
                     r_cath_s[4], r_cath_s[5], r_cath_s[6]};
        w_nybble  = 4'h0;
        w_legal   = 1'b1;
        case (w_abcdefg)
            7'b0000001: w_nybble = 4'h0;
            7'b1001111: w_nybble = 4'h1;
            7'b0010010: w_nybble = 4'h2;
            7'b0000110: w_nybble = 4'h3;
            7'b1001100: w_nybble = 4'h4;
            7'b0100100: w_nybble = 4'h5;
            7'b0100000: w_nybble = 4'h6;
            7'b0001111: w_nybble = 4'h7;
            7'b0000000: w_nybble = 4'h8;
            7'b0000100: w_nybble = 4'h9;
            7'b0001000: w_nybble = 4'hA;
            7'b1100000: w_nybble = 4'hB;
            7'b1110010: w_nybble = 4'hC;
            7'b1000010: w_nybble = 4'hD;
            7'b0110000: w_nybble = 4'hE;
            7'b0111000: w_nybble = 4'hF;
            default:    w_legal  = 1'b0;
        endcase
    end

    // Control FSM with registered digit outputs and frame tracking.
    // Digit outputs are written on the edge that enters CAPTURE so the
    // result appears SETTLE_CYCLES+4 edges after an input change; CAPTURE
    // itself is the single cycle during which the new value is presented.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_set   <= '0;
            r_data  <= '0;
            r_dp    <= '0;
            r_valid <= '0;
            r_err   <= '0;
            r_frame <= 1'b0;
        end else begin
            if (r_set == '1) begin
                r_frame <= 1'b1;
                r_set   <= w_cap_mask;
            end else begin
                r_frame <= 1'b0;
                r_set   <= r_set | w_cap_mask;
            end

            for (int unsigned k = 0; k < NUMBER_OF_NYBBLES; k++) begin
                if (w_cap_mask[k]) begin
                    if (w_legal) begin
                        r_data[4*k +: 4] <= w_nybble;
                        r_dp[k]          <= w_dp_bit;
                        r_valid[k]       <= 1'b1;
                    end else begin
                        r_err[k] <= 1'b1;
                    end
                end
            end

            case (r_state)
                IDLE: begin
                    if (w_onehot) r_state <= SETTLE;
                end
                SETTLE: begin
                    if (!w_onehot)      r_state <= IDLE;
                    else if (w_settled) r_state <= CAPTURE;
                end
                CAPTURE: begin
                    r_state <= HOLD;
                end
                HOLD: begin
                    // A counter below saturation also catches a change seen during CAPTURE
                    if (!w_onehot)       r_state <= IDLE;
                    else if (!w_settled) r_state <= SETTLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign data          = r_data;
    assign dp            = r_dp;
    assign digit_valid   = r_valid;
    assign pattern_error = r_err;
    assign frame_strobe  = r_frame;

endmodule

// File: doc/segmented_display_decoder.md
SEGMENTED_DISPLAY_DECODER -- requirements
Module: segmented_display_decoder

Interface
REQ-001 SHALL have parameter NUMBER_OF_NYBBLES, default 4, meaning count of multiplexed digits (anode width).
REQ-002 SHALL have parameter NUMBER_OF_SEGMENTS, default 7, meaning cathode width; legal values 7 (a..g) and 8 (a..g plus dp).
REQ-003 SHALL have parameter SETTLE_CYCLES, default 16, meaning consecutive stable cycles required before capture; legal range 1..255.
REQ-004 clock  input  1  sole clock; all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 anode  input  NUMBER_OF_NYBBLES  digit select, active-high, one-hot when valid; asynchronous to clock.
REQ-007 cathode  input  NUMBER_OF_SEGMENTS  segment drive, active-low; cathode[0]=a ... cathode[6]=g, cathode[7]=dp; asynchronous to clock.
REQ-008 data  output  NUMBER_OF_NYBBLES*4  decoded nybbles; digit k at data[4k+3:4k].
REQ-009 dp  output  NUMBER_OF_NYBBLES  decoded decimal points, active-high; forced 0 when NUMBER_OF_SEGMENTS=7.
REQ-010 digit_valid  output  NUMBER_OF_NYBBLES  bit k set once digit k has been captured with a legal pattern.
REQ-011 pattern_error  output  NUMBER_OF_NYBBLES  sticky; bit k set when digit k settled on an illegal pattern.
REQ-012 frame_strobe  output  1  one-cycle pulse when every digit has been captured since the previous pulse.

Function
REQ-013 anode and cathode SHALL each pass through a two-flop synchronizer; all logic below uses synchronized values (s_anode, s_cathode).
REQ-014 A stable counter SHALL reset to 0 on any cycle where {s_anode,s_cathode} differs from its value one cycle earlier, else increment, saturating at SETTLE_CYCLES.
REQ-015 State machine SHALL have states IDLE, SETTLE, CAPTURE, HOLD.
REQ-016 IDLE -> SETTLE when s_anode is one-hot; remain IDLE otherwise (zero or multiple bits set).
REQ-017 SETTLE -> IDLE if s_anode stops being one-hot; SETTLE -> CAPTURE when stable counter equals SETTLE_CYCLES.
REQ-018 CAPTURE lasts exactly one cycle, writes digit k = index of set s_anode bit, then -> HOLD.
REQ-019 HOLD -> SETTLE on any change of s_anode or s_cathode while s_anode remains one-hot; HOLD -> IDLE if s_anode stops being one-hot.
REQ-020 Decode table, segments a..g left to right, 0=lit: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=1110010, d=1000010, E=0110000, F=0111000.
REQ-021 On CAPTURE with a legal pattern: data nybble k, dp[k] (= ~cathode[7] when 8 segments) and digit_valid[k] SHALL update on the same edge.
REQ-022 On CAPTURE with an illegal pattern: pattern_error[k] SHALL set; data nybble k, dp[k], digit_valid[k] SHALL be unchanged.
REQ-023 An internal captured-set register SHALL set bit k on every CAPTURE (legal or not); when all bits are set, frame_strobe SHALL pulse on the following edge and the set SHALL clear on that edge; a CAPTURE on that same edge SHALL be retained in the new set.
REQ-024 Latency: with inputs changed once and then held, outputs SHALL update on exactly the (SETTLE_CYCLES+4)th rising edge after the change.
REQ-025 Recapture of an already-captured digit (cathode change under same anode) SHALL overwrite its nybble; no limit on repeats.
REQ-026 Anode glitches shorter than SETTLE_CYCLES SHALL cause no output change.

Reset
REQ-027 While reset_n=0: state IDLE, synchronizers, counter and captured-set 0; data, dp, digit_valid, pattern_error, frame_strobe all 0.
REQ-028 Deassertion of reset_n mid-scan SHALL start decoding fresh from IDLE; no output changes before a full SETTLE.

Verification
REQ-029 NUMBER_OF_NYBBLES=2, 7 segments: anode=01, cathode pattern "7", held 40 cycles -> data[3:0]=7, digit_valid=01 at edge 20 after change (SETTLE_CYCLES=16).
REQ-030 Scan anode 01/10 with patterns "1"/"8", 100 cycles each -> data=8'h81, digit_valid=11, one frame_strobe per two digits.
REQ-031 Anode=10, cathode a..g=1111111 held -> pattern_error=10, data and digit_valid unchanged.
REQ-032 Anode=11 or 00 held 100 cycles -> no capture, state IDLE, frame_strobe never pulses.
REQ-033 8 segments, anode=0001, pattern "A", cathode[7]=0 -> data[3:0]=A, dp=0001; 5-cycle cathode glitch afterwards -> no change.
REQ-034 reset_n pulsed low after digit 0 captured -> all outputs 0 immediately; recapture only after SETTLE_CYCLES+4 edges.
